rsa_controller: RTL and testbench
=================================

# rsa_controller

Top-level sequencer for the RSA datapath. On `init` it runs `key_generator` once and latches the key pair (N, e, d). It then shares a single external modular-exponentiation engine between an encrypt requester and a decrypt requester, using round-robin arbitration. It also range-checks operands and guards the engine with a watchdog.

## Interface
- `WORD_WIDTH`, 32, width of N, e, d, messages and results
- `TIMEOUT_CYCLES`, 4096, maximum cycles to wait for `mx_done` before aborting (≥ 2)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `init` in 1: single-cycle pulse that (re)generates keys; accepted only in IDLE or READY
- `ready` out 1: keys valid, requests serviceable
- `busy` out 1: high in every state except IDLE and READY
- `kg_start` out 1: single-cycle start pulse to `key_generator`
- `kg_done` in 1: key generator finished (level)
- `kg_N`, `kg_e`, `kg_d` in WORD_WIDTH: key outputs, valid while `kg_done`=1
- `enc_req` / `dec_req` in 1: request level, held until the matching ack
- `enc_msg` / `dec_msg` in WORD_WIDTH: operand, stable while req=1
- `enc_ack` / `dec_ack` out 1: single-cycle completion pulse
- `enc_err` / `dec_err` out 1: valid with ack; 1 = rejected or timed out
- `enc_result` / `dec_result` out WORD_WIDTH: valid with ack; 0 when err=1
- `mx_start` out 1: single-cycle start pulse to the modexp engine
- `mx_base`, `mx_exp`, `mx_mod` out WORD_WIDTH: operands, held from `mx_start` until the job ends
- `mx_done` in 1: engine finished (pulse or level; first high cycle counts)
- `mx_result` in WORD_WIDTH: valid while `mx_done`=1

## Operation
- States: IDLE, KG_START, KG_WAIT, READY, ARB, MX_START, MX_WAIT, RESP.
- Reset: state IDLE. All outputs 0. Latched keys 0. Round-robin pointer favours enc.
- IDLE: `init` → KG_START.
- READY: `init` → KG_START, and `ready` drops the next cycle. `init` is ignored in every other state.
- KG_START: `kg_start`=1 for one cycle → KG_WAIT.
- KG_WAIT: on `kg_done`=1, latch N, e, d → READY. There is no keygen timeout.
- READY with any req: → ARB.
  - If both requests are high, grant the requester not served last.
  - If only one is high, grant it.
  - `init` and req in the same cycle: `init` wins; requests stay pending.
- ARB: select operand (msg, e, N) for enc or (msg, d, N) for dec.
  - msg ≥ N → RESP with err=1, no engine start.
  - Otherwise → MX_START.
- MX_START: `mx_start`=1 for one cycle, drive operands, clear the watchdog → MX_WAIT.
- MX_WAIT:
  - On `mx_done`, capture `mx_result` → RESP with err=0.
  - If the watchdog reaches TIMEOUT_CYCLES first → RESP with err=1 and result 0.
- RESP: granted ack=1 with err/result for one cycle. Update the round-robin pointer (including on error) → READY.
- Requesters drop req on the edge that ends their ack cycle. Non-granted requests remain pending.
- Requests while not READY are held, never acked, and never dropped by the controller.
- `mx_*` operand outputs hold their last values outside a job. `*_result` outputs are registered and hold their value after ack.

## Timing
- `init` sampled at edge t: `kg_start` high in cycle t+1. `ready` is 0 from t+1 until the cycle after `kg_done` is sampled.
- `kg_done` sampled at edge k: `ready`=1 from cycle k+1.
- Req sampled in READY at edge r: ARB at r+1, `mx_start` at r+2.
- Accepted job: `mx_done` sampled at edge m gives ack at cycle m+1.
- Rejected operand: ack at r+2.
- Timeout: watchdog counts MX_WAIT cycles from 1. Count = TIMEOUT_CYCLES with no `mx_done` → ack the following cycle. `mx_done` in the same cycle as the timeout count wins, giving success.
- Back-to-back jobs: a pending request is re-sampled in READY the cycle after RESP. Minimum spacing between acks is 4 cycles plus engine latency.
- Asynchronous reset mid-job: immediately returns to IDLE with outputs 0 and keys cleared. The in-flight job is dropped with no ack.

## Test plan
- Init sequence: keygen model returns N=3233, e=17, d=2753 after 20 cycles. Require `kg_start` exactly once, one cycle wide; `ready`=1 one cycle after `kg_done`; `busy`=0.
- Encrypt then decrypt, with a modexp model of 10-cycle latency:
  - enc msg 65 → `enc_ack`, result 2790, err 0.
  - dec msg 2790 → `dec_ack`, result 65.
  - Check `mx_exp`=17 and then 2753, with `mx_mod`=3233.
- Contention: enc and dec both high for 3 jobs each. Require strict alternation enc, dec, enc, dec, enc, dec; exactly one ack per job; no overlap of `mx_start`.
- Range reject: enc msg 3233 → `enc_ack` with err=1, result 0, two cycles after sampling. No `mx_start` is issued.
- Timeout: TIMEOUT_CYCLES=16 and the engine never asserts done. Require ack with err=1 at cycle 17 of MX_WAIT, and the next request is serviced normally.
- Reset mid MX_WAIT: assert `rst`=0 asynchronously. Require all outputs 0 immediately; after release, `ready`=0 until a new `init`; requests held high stay unacked.

Source files
------------

// File: rtl/rsa_controller.sv
// ============================================================================
// rsa_controller
// Runs key generation once per init, then shares one modexp engine between
// encrypt and decrypt requesters with round-robin arbitration and a watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rsa_controller #(
   parameter int WORD_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  init_i,
   output logic                  ready_o,
   output logic                  busy_o,
   output logic                  kg_start_o,
   input  logic                  kg_done_i,
   input  logic [WORD_WIDTH-1:0] kg_n_i,
   input  logic [WORD_WIDTH-1:0] kg_e_i,
   input  logic [WORD_WIDTH-1:0] kg_d_i,
   input  logic                  enc_req_i,
   input  logic                  dec_req_i,
   input  logic [WORD_WIDTH-1:0] enc_msg_i,
   input  logic [WORD_WIDTH-1:0] dec_msg_i,
   output logic                  enc_ack_o,
   output logic                  dec_ack_o,
   output logic                  enc_err_o,
   output logic                  dec_err_o,
   output logic [WORD_WIDTH-1:0] enc_result_o,
   output logic [WORD_WIDTH-1:0] dec_result_o,
   output logic                  mx_start_o,
   output logic [WORD_WIDTH-1:0] mx_base_o,
   output logic [WORD_WIDTH-1:0] mx_exp_o,
   output logic [WORD_WIDTH-1:0] mx_mod_o,
   input  logic                  mx_done_i,
   input  logic [WORD_WIDTH-1:0] mx_result_i
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_KG_START = 3'd1,
      S_KG_WAIT  = 3'd2,
      S_READY    = 3'd3,
      S_ARB      = 3'd4,
      S_MX_START = 3'd5,
      S_MX_WAIT  = 3'd6,
      S_RESP     = 3'd7
   } state_e;

   state_e                state_q, state_d;
   logic [WORD_WIDTH-1:0] n_q, n_d, e_q, e_d, d_q, d_d;
   logic                  favor_dec_q, favor_dec_d;
   logic                  grant_dec_q, grant_dec_d;
   logic [WD_W-1:0]       wd_q, wd_d;
   logic                  enc_err_q, enc_err_d, dec_err_q, dec_err_d;
   logic [WORD_WIDTH-1:0] enc_res_q, enc_res_d, dec_res_q, dec_res_d;
   logic [WORD_WIDTH-1:0] mx_base_q, mx_base_d, mx_exp_q, mx_exp_d, mx_mod_q, mx_mod_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         e_q         <= '0;
         d_q         <= '0;
         favor_dec_q <= 1'b0;
         grant_dec_q <= 1'b0;
         wd_q        <= '0;
         enc_err_q   <= 1'b0;
         dec_err_q   <= 1'b0;
         enc_res_q   <= '0;
         dec_res_q   <= '0;
         mx_base_q   <= '0;
         mx_exp_q    <= '0;
         mx_mod_q    <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         e_q         <= e_d;
         d_q         <= d_d;
         favor_dec_q <= favor_dec_d;
         grant_dec_q <= grant_dec_d;
         wd_q        <= wd_d;
         enc_err_q   <= enc_err_d;
         dec_err_q   <= dec_err_d;
         enc_res_q   <= enc_res_d;
         dec_res_q   <= dec_res_d;
         mx_base_q   <= mx_base_d;
         mx_exp_q    <= mx_exp_d;
         mx_mod_q    <= mx_mod_d;
      end
   end

   always_comb begin
      logic                  w_fin;
      logic                  w_fin_err;
      logic [WORD_WIDTH-1:0] w_fin_res;
      logic [WORD_WIDTH-1:0] w_msg;

      state_d     = state_q;
      n_d         = n_q;
      e_d         = e_q;
      d_d         = d_q;
      favor_dec_d = favor_dec_q;
      grant_dec_d = grant_dec_q;
      wd_d        = wd_q;
      enc_err_d   = enc_err_q;
      dec_err_d   = dec_err_q;
      enc_res_d   = enc_res_q;
      dec_res_d   = dec_res_q;
      mx_base_d   = mx_base_q;
      mx_exp_d    = mx_exp_q;
      mx_mod_d    = mx_mod_q;
      w_fin       = 1'b0;
      w_fin_err   = 1'b0;
      w_fin_res   = '0;
      w_msg       = grant_dec_q ? dec_msg_i : enc_msg_i;

      case (state_q)
         S_IDLE: begin
            if (init_i) state_d = S_KG_START;
         end
         S_KG_START: state_d = S_KG_WAIT;
         S_KG_WAIT: begin
            if (kg_done_i) begin
               n_d     = kg_n_i;
               e_d     = kg_e_i;
               d_d     = kg_d_i;
               state_d = S_READY;
            end
         end
         S_READY: begin
            // init has priority; any request stays pending through keygen
            if (init_i) begin
               state_d = S_KG_START;
            end else if (enc_req_i || dec_req_i) begin
               grant_dec_d = (enc_req_i && dec_req_i) ? favor_dec_q : dec_req_i;
               state_d     = S_ARB;
            end
         end
         S_ARB: begin
            if (w_msg >= n_q) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
               state_d   = S_RESP;
            end else begin
               mx_base_d = w_msg;
               mx_exp_d  = grant_dec_q ? d_q : e_q;
               mx_mod_d  = n_q;
               state_d   = S_MX_START;
            end
         end
         S_MX_START: begin
            wd_d    = WD_W'(1);
            state_d = S_MX_WAIT;
         end
         S_MX_WAIT: begin
            // a done arriving on the final watchdog cycle still counts as success
            if (mx_done_i) begin
               w_fin     = 1'b1;
               w_fin_res = mx_result_i;
               state_d   = S_RESP;
            end else if (wd_q >= WD_W'(TIMEOUT_CYCLES)) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
               state_d   = S_RESP;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_RESP: begin
            favor_dec_d = ~grant_dec_q;
            state_d     = S_READY;
         end
         default: state_d = S_IDLE;
      endcase

      if (w_fin) begin
         if (grant_dec_q) begin
            dec_err_d = w_fin_err;
            dec_res_d = w_fin_res;
         end else begin
            enc_err_d = w_fin_err;
            enc_res_d = w_fin_res;
         end
      end
   end

   assign ready_o      = (state_q == S_READY);
   assign busy_o       = (state_q != S_IDLE) && (state_q != S_READY);
   assign kg_start_o   = (state_q == S_KG_START);
   assign mx_start_o   = (state_q == S_MX_START);
   assign enc_ack_o    = (state_q == S_RESP) && !grant_dec_q;
   assign dec_ack_o    = (state_q == S_RESP) &&  grant_dec_q;
   assign enc_err_o    = enc_err_q;
   assign dec_err_o    = dec_err_q;
   assign enc_result_o = enc_res_q;
   assign dec_result_o = dec_res_q;
   assign mx_base_o    = mx_base_q;
   assign mx_exp_o     = mx_exp_q;
   assign mx_mod_o     = mx_mod_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_controller.sv
// Directed bench for rsa_controller with keygen and modexp behavioural models.
`default_nettype none

module tb_rsa_controller;

   localparam int W   = 32;
   localparam int TMO = 16;
   localparam int LAT = 10;

   logic          clk, rst_n, init;
   logic          ready, busy, kg_start, kg_done;
   logic [W-1:0]  kg_n, kg_e, kg_d;
   logic          enc_req, dec_req, enc_ack, dec_ack, enc_err, dec_err;
   logic [W-1:0]  enc_msg, dec_msg, enc_result, dec_result;
   logic          mx_start, mx_done;
   logic [W-1:0]  mx_base, mx_exp, mx_mod, mx_result;

   rsa_controller #(.WORD_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .init_i(init),
      .ready_o(ready), .busy_o(busy), .kg_start_o(kg_start),
      .kg_done_i(kg_done), .kg_n_i(kg_n), .kg_e_i(kg_e), .kg_d_i(kg_d),
      .enc_req_i(enc_req), .dec_req_i(dec_req),
      .enc_msg_i(enc_msg), .dec_msg_i(dec_msg),
      .enc_ack_o(enc_ack), .dec_ack_o(dec_ack),
      .enc_err_o(enc_err), .dec_err_o(dec_err),
      .enc_result_o(enc_result), .dec_result_o(dec_result),
      .mx_start_o(mx_start), .mx_base_o(mx_base), .mx_exp_o(mx_exp), .mx_mod_o(mx_mod),
      .mx_done_i(mx_done), .mx_result_i(mx_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] m);
      logic [63:0] r, x;
      if (m == 0) return '0;
      r = 1;
      x = 64'(b) % 64'(m);
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = (r * x) % 64'(m);
         x = (x * x) % 64'(m);
      end
      return r[W-1:0];
   endfunction

   // Edge counter plus keygen and modexp engine models
   int          cyc = 0;
   int          starts = 0, kg_starts = 0;
   int          start_cyc = -1, done_cyc = -1, kg_done_cyc = -1;
   int          rem = 0, kg_rem = 0;
   bit          eng_en = 1'b1;
   logic [W-1:0] cap_base = '0, cap_exp = '0, cap_mod = '0;

   initial begin
      mx_done = 1'b0; mx_result = '0; kg_done = 1'b0;
      kg_n = 32'd3233; kg_e = 32'd17; kg_d = 32'd2753;
   end

   always @(posedge clk) begin
      cyc++;
      if (mx_done) done_cyc = cyc;
      if (kg_done) kg_done_cyc = cyc;
      if (!rst_n) begin
         rem = 0; kg_rem = 0;
      end else begin
         if (mx_start) begin
            starts++; start_cyc = cyc; rem = LAT;
            cap_base = mx_base; cap_exp = mx_exp; cap_mod = mx_mod;
         end else if (rem > 0) rem--;
         if (kg_start) begin
            kg_starts++; kg_rem = 20;
         end else if (kg_rem > 0) kg_rem--;
      end
      #1;
      mx_done   = eng_en && (rem == 1);
      mx_result = mx_done ? modexp(cap_base, cap_exp, cap_mod) : '0;
      kg_done   = (kg_rem == 1);
   end

   typedef struct {
      bit          is_dec;
      logic [W-1:0] msg;
      bit          exp_err;
      logic [W-1:0] exp_res;
      bit          tmo;
   } vec_t;

   bit last_dec = 1'b1;

   task automatic all_zero(input string tag);
      chk({tag, "_ready"}, ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ctl"}, {kg_start, mx_start, enc_ack, dec_ack, enc_err, dec_err}, 0);
      chk({tag, "_results"}, {enc_result, dec_result}, 0);
      chk({tag, "_mx_ops"}, mx_base | mx_exp | mx_mod, 0);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int  c0, s0, ack_cyc;
      bit  got;
      logic            g_err;
      logic [W-1:0]    g_res;
      c0 = cyc; s0 = starts; got = 0; ack_cyc = -1; g_err = 1'bx; g_res = 'x;
      if (v.is_dec) begin dec_msg = v.msg; dec_req = 1'b1; end
      else          begin enc_msg = v.msg; enc_req = 1'b1; end
      for (int k = 0; k < 200 && !got; k++) begin
         @(posedge clk); #1;
         if (v.is_dec ? dec_ack : enc_ack) begin
            got = 1; ack_cyc = cyc;
            g_err = v.is_dec ? dec_err : enc_err;
            g_res = v.is_dec ? dec_result : enc_result;
            chk({tag, "_other_ack"}, v.is_dec ? enc_ack : dec_ack, 0);
         end
      end
      enc_req = 1'b0; dec_req = 1'b0;
      chk({tag, "_ack_seen"}, got, 1);
      chk({tag, "_err"}, g_err, v.exp_err);
      chk({tag, "_result"}, g_res, v.exp_res);
      if (v.exp_err && !v.tmo) begin
         chk({tag, "_no_start"}, starts - s0, 0);
         chk({tag, "_reject_lat"}, ack_cyc - c0, 2);
      end else begin
         chk({tag, "_one_start"}, starts - s0, 1);
         chk({tag, "_start_lat"}, start_cyc - c0, 3);
         chk({tag, "_mx_exp"}, cap_exp, v.is_dec ? 32'd2753 : 32'd17);
         chk({tag, "_mx_mod"}, cap_mod, 32'd3233);
         if (v.tmo) chk({tag, "_tmo_lat"}, ack_cyc - start_cyc, TMO);
         else       chk({tag, "_done_lat"}, ack_cyc, done_cyc);
      end
      last_dec = v.is_dec;
      @(posedge clk); #1;
      chk({tag, "_result_hold"}, v.is_dec ? dec_result : enc_result, v.exp_res);
      chk({tag, "_ack_once"}, enc_ack | dec_ack, 0);
   endtask

   initial begin
      vec_t vecs[8];
      int   kgs0, kgc, rdy_cyc, enc_left, dec_left, s0;
      bit   exp_dec, got, seen_bad;

      vecs[0] = '{0, 32'd65,   0, 32'd2790, 0};
      vecs[1] = '{1, 32'd2790, 0, 32'd65,   0};
      vecs[2] = '{0, 32'd3233, 1, 32'd0,    0};
      vecs[3] = '{1, 32'd5000, 1, 32'd0,    0};
      vecs[4] = '{0, 32'd2,    0, 32'd1752, 0};
      vecs[5] = '{0, 32'd0,    0, 32'd0,    0};
      vecs[6] = '{0, 32'd3232, 0, 32'd3232, 0};
      vecs[7] = '{1, 32'd1,    0, 32'd1,    0};

      rst_n = 1'b0; init = 1'b0;
      enc_req = 1'b0; dec_req = 1'b0; enc_msg = '0; dec_msg = '0;
      repeat (3) @(posedge clk);
      #1;
      all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Key generation
      kgs0 = kg_starts; kgc = 0; rdy_cyc = -1;
      init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      chk("init_kg_start", kg_start, 1);
      chk("init_busy", busy, 1);
      for (int k = 0; k < 60 && rdy_cyc < 0; k++) begin
         if (kg_start) kgc++;
         @(posedge clk); #1;
         if (ready) rdy_cyc = cyc;
      end
      chk("init_kg_start_once", kgc, 1);
      chk("init_kg_model_starts", kg_starts - kgs0, 1);
      chk("init_ready_after_done", rdy_cyc, kg_done_cyc);
      chk("init_ready_busy", busy, 0);

      foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Contention: both requesters, three jobs each
      enc_left = 3; dec_left = 3; exp_dec = !last_dec; s0 = starts;
      enc_msg = 32'd65; dec_msg = 32'd2790; enc_req = 1'b1; dec_req = 1'b1;
      for (int j = 0; j < 6; j++) begin
         got = 0;
         for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk); #1;
            if (enc_ack || dec_ack) got = 1;
         end
         chk($sformatf("cont%0d_ack_seen", j), got, 1);
         chk($sformatf("cont%0d_single_ack", j), enc_ack & dec_ack, 0);
         chk($sformatf("cont%0d_grant_dec", j), dec_ack, exp_dec);
         chk($sformatf("cont%0d_result", j), dec_ack ? dec_result : enc_result,
             dec_ack ? 32'd65 : 32'd2790);
         chk($sformatf("cont%0d_starts", j), starts - s0, j + 1);
         if (dec_ack) begin dec_left--; if (dec_left == 0) dec_req = 1'b0; end
         else         begin enc_left--; if (enc_left == 0) enc_req = 1'b0; end
         last_dec = dec_ack;
         exp_dec = !exp_dec;
      end
      enc_req = 1'b0; dec_req = 1'b0;
      @(posedge clk); #1;

      // Watchdog expiry, then a normal job
      eng_en = 1'b0;
      run_vec("tmo", '{0, 32'd100, 1, 32'd0, 1});
      eng_en = 1'b1;
      run_vec("post_tmo", '{1, 32'd2790, 0, 32'd65, 0});

      // init and request in the same READY cycle: init wins, request survives
      kgs0 = kg_starts;
      enc_msg = 32'd2; enc_req = 1'b1; init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      chk("init_req_kg_start", kg_start, 1);
      chk("init_req_ready", ready, 0);
      got = 0;
      for (int k = 0; k < 80 && !got; k++) begin
         @(posedge clk); #1;
         if (enc_ack) got = 1;
      end
      enc_req = 1'b0;
      chk("init_req_ack", got, 1);
      chk("init_req_result", enc_result, 32'd1752);
      chk("init_req_regen", kg_starts - kgs0, 1);
      @(posedge clk); #1;

      // Asynchronous reset in MX_WAIT
      eng_en = 1'b0;
      enc_msg = 32'd65; enc_req = 1'b1;
      repeat (6) @(posedge clk);
      #4;
      chk("rst_in_job_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      all_zero("rst_mid");
      @(posedge clk); #1;
      rst_n = 1'b1;
      eng_en = 1'b1;
      seen_bad = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (enc_ack || ready || busy) seen_bad = 1;
      end
      chk("rst_after_no_ack_no_ready", seen_bad, 0);
      enc_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "bench timeout");
   end

endmodule

`default_nettype wire
